// File: rtl/clock_display_driver.sv
`timescale 1ns/1ps
// clock_display_driver: converts binary h/m/s to BCD and scans a 6-digit common-anode 7-segment display.
// Ports: clock, reset_n (async, active-low); hours[3:0], minutes[5:0], seconds[5:0], am_pm, alarm_ringing in;
//        anode_n[5:0] digit enables, seg_n[6:0] {g,f,e,d,c,b,a}, dp_n decimal point, all active-low out.
// Macro LEAD_ZERO_BLANK_EN: when defined, digit 5 is blanked while the hours tens digit is zero.
module clock_display_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int FLASH_DIV = 25000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       am_pm,
    input  logic       alarm_ringing,
    output logic [5:0] anode_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t state;
    logic [16:0] v, v_d, snap;
    logic [3:0] h, ht, mt, st;
    logic [5:0] m, s;
    logic [5:0][3:0] dig;
    logic disp_pm;
    logic [SW-1:0] scan_cnt;
    logic [FW-1:0] flash_cnt;
    logic flash_phase;
    logic [2:0] idx;
    logic [3:0] cur;
    logic blank, dp_cur, scan_wrap, flash_wrap;
    logic [6:0] seg_cur;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction
    assign v = {hours, minutes, seconds, am_pm};
    // Converter: a conversion starts only from a snapshot of an input that held for a full cycle,
    // and results reach the display registers together in COMMIT so no digit mix is ever shown.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            v_d     <= '0;
            snap    <= '0;
            h       <= '0;
            m       <= '0;
            s       <= '0;
            ht      <= '0;
            mt      <= '0;
            st      <= '0;
            dig     <= '0;
            disp_pm <= 1'b0;
        end else begin
            v_d <= v;
            case (state)
                IDLE: if (v == v_d && v_d != snap) begin
                    snap  <= v_d;
                    h     <= v_d[16:13];
                    m     <= v_d[12:7];
                    s     <= v_d[6:1];
                    ht    <= '0;
                    mt    <= '0;
                    st    <= '0;
                    state <= CONV;
                end
                CONV: begin
                    h  <= (h >= 4'd10) ? h - 4'd10 : h;
                    m  <= (m >= 6'd10) ? m - 6'd10 : m;
                    s  <= (s >= 6'd10) ? s - 6'd10 : s;
                    ht <= (h >= 4'd10) ? ht + 4'd1 : ht;
                    mt <= (m >= 6'd10) ? mt + 4'd1 : mt;
                    st <= (s >= 6'd10) ? st + 4'd1 : st;
                    if (h < 4'd10 && m < 6'd10 && s < 6'd10)
                        state <= COMMIT;
                end
                COMMIT: begin
                    dig     <= {ht, h, mt, m[3:0], st, s[3:0]};
                    disp_pm <= snap[0];
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign cur = dig[idx];
`ifdef LEAD_ZERO_BLANK_EN
    assign blank = (idx == 3'd5) && (dig[5] == 4'd0);
`else
    assign blank = 1'b0;
`endif
    assign seg_cur    = blank ? 7'h7F : seg7(cur);
    assign dp_cur     = !((((idx == 3'd4) || (idx == 3'd2)) && !dig[0][0]) || ((idx == 3'd0) && disp_pm));
    assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    assign flash_wrap = flash_cnt == FW'(FLASH_DIV - 1);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt    <= '0;
            idx         <= '0;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
            anode_n     <= 6'b111111;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap)
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            flash_cnt   <= (!alarm_ringing || flash_wrap) ? '0 : flash_cnt + 1'b1;
            flash_phase <= alarm_ringing && (flash_phase ^ flash_wrap);
            // Flash blanking only gates the anodes; the scan itself keeps running.
            anode_n <= flash_phase ? 6'b111111 : ~(6'd1 << idx);
            seg_n   <= seg_cur;
            dp_n    <= dp_cur;
        end
    end
endmodule
